pipe_skid_reg: RTL

- Parametrised, handshaked pipeline-stage register for the in-order MIPS core; replaces fixed per-stage latches such as ID/EX and EX/MEM.
- Carries a control bundle (zeroed to form a bubble) and a data bundle between stages with valid/ready flow control.
- Two-entry skid buffer keeps in_ready registered, so no combinational path from out_ready to in_ready.
- Supports synchronous flush for branch/exception squash and a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_skid_reg.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - handshaked pipeline-stage register with two-entry skid buffer,
// flush and a saturating stall counter.
module pipe_skid_reg #(
  parameter int DATA_W     = 128,
  parameter int CTRL_W     = 16,
  parameter int CNT_W      = 16,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_data = main_data;
  // Bubble masking: downstream never sees control bits without a valid entry.
  assign out_ctrl = out_valid ? main_ctrl : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        state     <= EMPTY;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        main_ctrl <= '0;
        skid_ctrl <= '0;
        if (CLEAR_DATA != 0) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state     <= FULL;
              out_valid <= 1'b1;
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end
          end
          FULL: begin
            if (in_fire && out_ready) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end else if (in_fire) begin
              // Head is stalled: park the newcomer behind it and close the input.
              state     <= SKID;
              in_ready  <= 1'b0;
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
            end else if (out_ready) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              main_ctrl <= '0;
              if (CLEAR_DATA != 0) main_data <= '0;
            end
          end
          SKID: begin
            if (out_ready) begin
              state     <= FULL;
              in_ready  <= 1'b1;
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
              skid_ctrl <= '0;
              if (CLEAR_DATA != 0) skid_data <= '0;
            end
          end
          default: begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
          end
        endcase
      end
    end
  end

endmodule
